// File: rtl/ram_fill_ctrl.sv
// rtl/ram_fill_ctrl.sv - SRAM background fill engine using Z80 refresh slots
// Writes a constant byte across a wrapping address range; otherwise passes decoder signals through.
module ram_fill_ctrl #(
   parameter int ADR_W = 20
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [7:0]       fill_data,
   input  logic [ADR_W-1:0] start_adr,
   input  logic [ADR_W-1:0] end_adr,
   input  logic             mreq_b,
   input  logic             rfsh_b,
   input  logic             cpu_ramcs0_b,
   input  logic             cpu_ramcs1_b,
   input  logic             cpu_ramoe_b,
   input  logic             cpu_ramwe_b,
   input  logic [4:0]       cpu_ramadrhi,
   input  logic [13:0]      cpu_adr,
   output logic             ramcs0_b,
   output logic             ramcs1_b,
   output logic             ramoe_b,
   output logic             ramwe_b,
   output logic [4:0]       ramadrhi,
   output logic [13:0]      ramadrlo,
   output logic [7:0]       ram_dout,
   output logic             ram_doe,
   output logic             busy,
   output logic             done,
   output logic             aborted
);

   typedef enum logic [1:0] {IDLE, WAIT_SLOT, WRITE, RECOVER} state_t;

   state_t           state, state_d;
   logic [ADR_W-1:0] adr_q, end_q;
   logic [7:0]       data_q;
   logic             abort_pend;
   logic             slot, owned;
   logic             load, advance, finish, take_abort;

   assign slot = ~mreq_b & ~rfsh_b;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_d;
   end

   always_comb begin
      state_d    = state;
      load       = 1'b0;
      advance    = 1'b0;
      finish     = 1'b0;
      take_abort = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load    = 1'b1;
               state_d = WAIT_SLOT;
            end
         end
         WAIT_SLOT: begin
            // A deferred abort is honoured here, never mid-write
            if (abort || abort_pend) begin
               take_abort = 1'b1;
               state_d    = IDLE;
            end else if (slot) begin
               state_d = WRITE;
            end
         end
         WRITE: begin
            if (slot) begin
               if (adr_q == end_q) begin
                  finish  = 1'b1;
                  state_d = IDLE;
               end else begin
                  advance = 1'b1;
                  state_d = RECOVER;
               end
            end else begin
               state_d = WAIT_SLOT;
            end
         end
         RECOVER: begin
            if (mreq_b) state_d = WAIT_SLOT;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         adr_q      <= '0;
         end_q      <= '0;
         data_q     <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         aborted    <= 1'b0;
         abort_pend <= 1'b0;
      end else begin
         done <= finish;
         if (load) begin
            adr_q      <= start_adr;
            end_q      <= end_adr;
            data_q     <= fill_data;
            busy       <= 1'b1;
            aborted    <= 1'b0;
            abort_pend <= 1'b0;
         end
         if (abort && (state == WRITE || state == RECOVER))
            abort_pend <= 1'b1;
         if (advance)
            adr_q <= adr_q + ADR_W'(1);
         if (finish) begin
            busy       <= 1'b0;
            abort_pend <= 1'b0;
         end
         if (take_abort) begin
            aborted    <= 1'b1;
            busy       <= 1'b0;
            abort_pend <= 1'b0;
         end
      end
   end

   // Strobe follows the live slot so it releases the instant the refresh cycle ends
   assign owned    = (state == WRITE);
   assign ramcs0_b = owned ? (adr_q[ADR_W-1] ? 1'b1 : mreq_b) : cpu_ramcs0_b;
   assign ramcs1_b = owned ? (adr_q[ADR_W-1] ? mreq_b : 1'b1) : cpu_ramcs1_b;
   assign ramoe_b  = owned ? 1'b1 : cpu_ramoe_b;
   assign ramwe_b  = owned ? (mreq_b | rfsh_b) : cpu_ramwe_b;
   assign ramadrhi = owned ? adr_q[18:14] : cpu_ramadrhi;
   assign ramadrlo = owned ? adr_q[13:0] : cpu_adr;
   assign ram_dout = data_q;
   assign ram_doe  = owned;

endmodule

// File: tb/tb_ram_fill_ctrl.sv
// tb/tb_ram_fill_ctrl.sv - self-checking bench for ram_fill_ctrl
// Observed SRAM writes are compared with an arithmetic model of the fill range.
module tb_ram_fill_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        start, abort;
   logic [7:0]  fill_data;
   logic [19:0] start_adr, end_adr;
   logic        mreq_b, rfsh_b;
   logic        cpu_ramcs0_b, cpu_ramcs1_b, cpu_ramoe_b, cpu_ramwe_b;
   logic [4:0]  cpu_ramadrhi;
   logic [13:0] cpu_adr;
   logic        ramcs0_b, ramcs1_b, ramoe_b, ramwe_b;
   logic [4:0]  ramadrhi;
   logic [13:0] ramadrlo;
   logic [7:0]  ram_dout;
   logic        ram_doe, busy, done, aborted;

   int checks = 0;
   int errors = 0;

   logic [19:0] wr_adr[$];
   logic [7:0]  wr_dat[$];
   int          done_cnt, cs_bad;

   ram_fill_ctrl #(.ADR_W(20)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .fill_data(fill_data), .start_adr(start_adr), .end_adr(end_adr),
      .mreq_b(mreq_b), .rfsh_b(rfsh_b),
      .cpu_ramcs0_b(cpu_ramcs0_b), .cpu_ramcs1_b(cpu_ramcs1_b),
      .cpu_ramoe_b(cpu_ramoe_b), .cpu_ramwe_b(cpu_ramwe_b),
      .cpu_ramadrhi(cpu_ramadrhi), .cpu_adr(cpu_adr),
      .ramcs0_b(ramcs0_b), .ramcs1_b(ramcs1_b), .ramoe_b(ramoe_b), .ramwe_b(ramwe_b),
      .ramadrhi(ramadrhi), .ramadrlo(ramadrlo), .ram_dout(ram_dout), .ram_doe(ram_doe),
      .busy(busy), .done(done), .aborted(aborted)
   );

   always #5 clk = ~clk;

   // Inputs only change just after posedge, so a strobe seen here is still present at the next edge
   always @(negedge clk) begin
      if (ram_doe === 1'b1 && ramwe_b === 1'b0) begin
         if (ramcs0_b === ramcs1_b) cs_bad++;
         wr_adr.push_back({~ramcs1_b, ramadrhi, ramadrlo});
         wr_dat.push_back(ram_dout);
      end
      if (done === 1'b1) done_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      wr_adr.delete();
      wr_dat.delete();
      done_cnt = 0;
      cs_bad   = 0;
   endtask

   task automatic do_start(input logic [19:0] s, input logic [19:0] e, input logic [7:0] d);
      start_adr = s;
      end_adr   = e;
      fill_data = d;
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   task automatic run_slots(input int k);
      for (int i = 0; i < k; i++) begin
         mreq_b = 1'b0;
         rfsh_b = 1'b0;
         tick();
         tick();
         mreq_b = 1'b1;
         rfsh_b = 1'b1;
         repeat ($urandom_range(1, 3)) tick();
      end
   endtask

   task automatic check_pass(input string tag, input logic [7:0] dexp);
      chk({tag, "_pass"},
          {12'd0, ramcs0_b, ramcs1_b, ramoe_b, ramwe_b, ramadrhi, ramadrlo},
          {12'd0, cpu_ramcs0_b, cpu_ramcs1_b, cpu_ramoe_b, cpu_ramwe_b, cpu_ramadrhi, cpu_adr});
      chk({tag, "_doe"}, {31'd0, ram_doe}, 32'd0);
      chk({tag, "_dout"}, {24'd0, ram_dout}, {24'd0, dexp});
   endtask

   // Expected writes: every address from s to e inclusive, modulo 2^20
   task automatic check_fill(input string tag, input logic [19:0] s, input logic [19:0] e,
                             input logic [7:0] d);
      logic [19:0] span, a;
      int n;
      span = e - s;
      n = int'(span) + 1;
      chk({tag, "_count"}, wr_adr.size(), n);
      for (int i = 0; i < n && i < wr_adr.size(); i++) begin
         a = s + 20'(i);
         chk($sformatf("%s_adr%0d", tag, i), {12'd0, wr_adr[i]}, {12'd0, a});
         chk($sformatf("%s_dat%0d", tag, i), {24'd0, wr_dat[i]}, {24'd0, d});
      end
      chk({tag, "_done"}, done_cnt, 1);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_cs"}, cs_bad, 0);
   endtask

   initial begin
      logic [19:0] s, e;
      logic [7:0]  d;
      int          len;

      reset = 1'b1; start = 1'b0; abort = 1'b0;
      fill_data = 8'h00; start_adr = '0; end_adr = '0;
      mreq_b = 1'b1; rfsh_b = 1'b1;
      cpu_ramcs0_b = 1'b1; cpu_ramcs1_b = 1'b1; cpu_ramoe_b = 1'b1; cpu_ramwe_b = 1'b1;
      cpu_ramadrhi = 5'h00; cpu_adr = 14'h0000;
      clear_log();
      tick();
      tick();

      // Reset state with arbitrary decoder values
      cpu_ramcs0_b = 1'b0; cpu_ramoe_b = 1'b0; cpu_ramadrhi = 5'($urandom); cpu_adr = 14'($urandom);
      #1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_aborted", {31'd0, aborted}, 32'd0);
      check_pass("rst", 8'h00);
      reset = 1'b0;
      cpu_ramcs0_b = 1'b1; cpu_ramoe_b = 1'b1;
      tick();

      // Basic four-byte fill into SRAM0
      clear_log();
      do_start(20'h00000, 20'h00003, 8'hA5);
      chk("basic_busy_rise", {31'd0, busy}, 32'd1);
      run_slots(4);
      check_fill("basic", 20'h00000, 20'h00003, 8'hA5);

      // Wrap across the top of SRAM1 into SRAM0
      clear_log();
      do_start(20'hFFFFE, 20'h00001, 8'h3C);
      run_slots(4);
      check_fill("wrap", 20'hFFFFE, 20'h00001, 8'h3C);

      // Truncated slot on 0x00010 must be retried
      clear_log();
      do_start(20'h0000F, 20'h00011, 8'h5A);
      run_slots(1);
      mreq_b = 1'b0; rfsh_b = 1'b0;
      tick();
      mreq_b = 1'b1; rfsh_b = 1'b1;
      tick();
      tick();
      chk("trunc_mid_count", wr_adr.size(), 1);
      run_slots(2);
      check_fill("trunc", 20'h0000F, 20'h00011, 8'h5A);

      // CPU read cycle during a fill passes straight through
      clear_log();
      do_start(20'h12345, 20'h12346, 8'hC3);
      mreq_b = 1'b0; rfsh_b = 1'b1;
      cpu_ramcs0_b = 1'b0; cpu_ramoe_b = 1'b0; cpu_ramadrhi = 5'h15; cpu_adr = 14'($urandom);
      tick();
      check_pass("cpurd1", 8'hC3);
      tick();
      check_pass("cpurd2", 8'hC3);
      chk("cpurd_busy", {31'd0, busy}, 32'd1);
      mreq_b = 1'b1; cpu_ramcs0_b = 1'b1; cpu_ramoe_b = 1'b1;
      tick();
      run_slots(2);
      check_fill("cpurd", 20'h12345, 20'h12346, 8'hC3);

      // Abort in WAIT_SLOT after two commits of an eight-byte fill
      clear_log();
      do_start(20'h40000, 20'h40007, 8'h77);
      run_slots(2);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_flag", {31'd0, aborted}, 32'd1);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      run_slots(2);
      chk("abort_count", wr_adr.size(), 2);
      chk("abort_done", done_cnt, 0);
      clear_log();
      do_start(20'h00020, 20'h00020, 8'h11);
      chk("restart_aborted", {31'd0, aborted}, 32'd0);
      chk("restart_busy", {31'd0, busy}, 32'd1);
      run_slots(1);
      check_fill("single", 20'h00020, 20'h00020, 8'h11);

      // Start and abort together in IDLE: start wins
      clear_log();
      abort = 1'b1;
      do_start(20'h00100, 20'h00101, 8'h42);
      abort = 1'b0;
      chk("startabort_busy", {31'd0, busy}, 32'd1);
      run_slots(2);
      check_fill("startabort", 20'h00100, 20'h00101, 8'h42);

      // Randomized fills against the range model
      for (int it = 0; it < 8; it++) begin
         clear_log();
         s   = (it % 2 == 1) ? (20'hFFFFF - 20'($urandom_range(0, 3))) : 20'($urandom);
         len = $urandom_range(1, 6);
         e   = s + 20'(len - 1);
         d   = 8'($urandom);
         do_start(s, e, d);
         run_slots(len);
         check_fill($sformatf("rnd%0d", it), s, e, d);
      end

      // Ignored start while busy, then reset during WRITE
      clear_log();
      do_start(20'h80010, 20'h80013, 8'h9E);
      do_start(20'h00500, 20'h00600, 8'h01);
      run_slots(1);
      chk("ign_count", wr_adr.size(), 1);
      if (wr_adr.size() > 0) begin
         chk("ign_adr", {12'd0, wr_adr[0]}, 32'h80010);
         chk("ign_dat", {24'd0, wr_dat[0]}, 32'h9E);
      end
      mreq_b = 1'b0; rfsh_b = 1'b0;
      tick();
      chk("wr_doe", {31'd0, ram_doe}, 32'd1);
      chk("wr_we", {31'd0, ramwe_b}, 32'd0);
      #2 reset = 1'b1;
      #1;
      chk("rstwr_doe", {31'd0, ram_doe}, 32'd0);
      chk("rstwr_we", {31'd0, ramwe_b}, {31'd0, cpu_ramwe_b});
      chk("rstwr_busy", {31'd0, busy}, 32'd0);
      check_pass("rstwr", 8'h00);
      #1 reset = 1'b0;
      mreq_b = 1'b1; rfsh_b = 1'b1;
      tick();
      chk("rstwr_idle_busy", {31'd0, busy}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ram_fill_ctrl.md
# ram_fill_ctrl

Background fill engine and SRAM arbiter for the 1MB expansion board. It writes a constant byte across a programmable range of the two 512KB SRAMs, using only Z80 refresh slots (`mreq_b`=0, `rfsh_b`=0) so CPU memory timing is never disturbed. Outside a refresh slot it passes the decoder's chip-select, enable and address signals straight through to the SRAMs. It sits between the existing RAM decode logic and the SRAM pins.

## Interface
Parameters:
- `ADR_W`, 20: byte address width across both SRAMs. Bit 19 selects the SRAM: 0 is SRAM0, 1 is SRAM1.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  Z80 clock.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  single-cycle request. Latches `fill_data`, `start_adr` and `end_adr`. Ignored while `busy`=1.
- `abort`  in  1  single-cycle request to stop a running fill.
- `fill_data`  in  8  byte to write.
- `start_adr`, `end_adr`  in  20 each  inclusive range. The range wraps past 0xFFFFF if `end_adr` < `start_adr`.
- `mreq_b`, `rfsh_b`  in  1 each  Z80 bus.
- `cpu_ramcs0_b`, `cpu_ramcs1_b`, `cpu_ramoe_b`, `cpu_ramwe_b`  in  1 each  from the decoder.
- `cpu_ramadrhi`  in  5  from the decoder.
- `cpu_adr`  in  14  Z80 A13..A0.
- `ramcs0_b`, `ramcs1_b`, `ramoe_b`, `ramwe_b`  out  1 each  to the SRAMs.
- `ramadrhi`  out  5  SRAM A18..A14.
- `ramadrlo`  out  14  SRAM A13..A0.
- `ram_dout`  out  8  write data.
- `ram_doe`  out  1  data driver enable.
- `busy`  out  1  fill in progress.
- `done`  out  1  1-cycle pulse when the fill completes.
- `aborted`  out  1  sticky flag. Cleared by the next accepted `start`.

## Operation
State machine states:
- IDLE: not filling.
- WAIT_SLOT: waiting for a refresh slot.
- WRITE: driving one byte onto the SRAM.
- RECOVER: waiting for the refresh slot to end.

Ownership:
- `owned` is 1 only in WRITE.
- When `owned`=0, every SRAM output equals its `cpu_*` input combinationally, `ram_doe`=0 and `ram_dout`=`fill_data` latch.

Outputs when `owned`=1:
- The chip select for address bit 19 is driven to `mreq_b`; the other chip select is 1.
- `ramadrhi` = `adr_q`[18:14] and `ramadrlo` = `adr_q`[13:0].
- `ramoe_b`=1.
- `ramwe_b` = `mreq_b` | `rfsh_b`. This is gated combinationally so the write strobe drops the instant the slot ends.
- `ram_doe`=1.

Transitions (all at posedge `clk`):
- IDLE, `start`: load `adr_q`=`start_adr`, `end_q`=`end_adr`, `data_q`=`fill_data`. Set `busy`=1, clear `aborted`, go to WAIT_SLOT.
- WAIT_SLOT, `abort`: set `aborted`=1, `busy`=0, go to IDLE. `done` is not pulsed.
- WAIT_SLOT, slot present (`mreq_b`=0 and `rfsh_b`=0): go to WRITE.
- WRITE, slot still present at the next posedge: the write is committed.
  - If `adr_q`==`end_q`: `done`=1 for one cycle, `busy`=0, go to IDLE.
  - Otherwise: `adr_q`=`adr_q`+1 modulo 2^20 (0xFFFFF wraps to 0x00000), go to RECOVER.
- WRITE, slot gone: write not committed. `adr_q` is unchanged, go to WAIT_SLOT and retry the same byte.
- RECOVER, `mreq_b`=1: go to WAIT_SLOT. This guarantees at most one byte per refresh slot.
- `abort` received in WRITE or RECOVER: held pending and taken at the next WAIT_SLOT entry. A committed write is never reverted.
- `start` with `busy`=1: ignored; no latched value changes.
- `start` and `abort` in the same cycle in IDLE: `start` wins.
- `start_adr`==`end_adr`: exactly one byte is written.

Arithmetic and width:
- `adr_q` and `end_q` are 20-bit unsigned.
- A full-range fill (start 0x00000, end 0xFFFFF) is 1,048,576 commits.

## Timing
- Reset (asynchronous): state IDLE, `busy`=0, `done`=0, `aborted`=0, `adr_q`=0, `end_q`=0, `data_q`=0, abort pending cleared.
  - After reset all SRAM outputs pass through the `cpu_*` inputs and `ram_doe`=0.
  - Reset during WRITE deasserts `ram_doe` and the engine's `ramwe_b` immediately; outputs return to pass-through.
- `busy` rises the cycle after `start`.
- Minimum latency from `start` to the first write strobe is 2 clocks: one to enter WAIT_SLOT, one for the slot to be sampled.
- The write strobe is low from entry to WRITE until slot end or exit from WRITE, whichever comes first.
- `done` is high for exactly the one cycle following the final commit.
- CPU cycles with `rfsh_b`=1 are never delayed or altered.

## Test plan
- Fill start 0x00000, end 0x00003, data 0xA5, with 4 full refresh slots → 4 SRAM0 write strobes at addresses 0..3 with `ram_dout`=0xA5; `done` pulses after the 4th; `busy`=0.
- Wrap: start 0xFFFFE, end 0x00001 → writes at FFFFE and FFFFF on `ramcs1_b`, then 00000 and 00001 on `ramcs0_b`; exactly one `done`.
- Truncated slot (`mreq_b` rises before the WRITE posedge) on address 0x00010 → no commit; the next slot rewrites 0x00010; total commits equal the range length.
- CPU read cycle (`rfsh_b`=1, `mreq_b`=0, `cpu_ramoe_b`=0, `cpu_ramadrhi`=0x15) while `busy`=1 → outputs equal the `cpu_*` inputs and `ram_doe`=0.
- `abort` in WAIT_SLOT after 2 commits of an 8-byte fill → `aborted`=1, `busy`=0, no `done`, no further strobes. A subsequent `start` clears `aborted`.
- `reset` asserted in WRITE → `ram_doe`=0, `ramwe_b`=`cpu_ramwe_b` immediately; `busy`=0; a `start` issued during `busy` before the reset left no latched change.
